// File: rtl/dataless_chain_arbiter_if.sv
// Handshake bundle between dataless requesters, the shared chain entry and its credit return.
// The master modport is the arbiter's view; the slave modport is the surrounding environment.
interface dataless_chain_arbiter_if #(
    parameter int NUM_INPUTS   = 4,
    parameter int MAX_INFLIGHT = 4,
    parameter int INDEX_WIDTH  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
    parameter int CNT_WIDTH    = $clog2(MAX_INFLIGHT + 1)
);
    logic [NUM_INPUTS-1:0]  ins_valid;
    logic [NUM_INPUTS-1:0]  ins_ready;
    logic                   outs_valid;
    logic                   outs_ready;
    logic [INDEX_WIDTH-1:0] index;
    logic                   ret_valid;
    logic [CNT_WIDTH-1:0]   inflight;
    logic                   err;

    modport master (
        input  ins_valid, outs_ready, ret_valid,
        output ins_ready, outs_valid, index, inflight, err
    );

    modport slave (
        output ins_valid, outs_ready, ret_valid,
        input  ins_ready, outs_valid, index, inflight, err
    );
endinterface

// File: rtl/dataless_chain_arbiter.sv
// Round-robin arbiter plus credit counter feeding one shared dataless OEHB chain.
// Optional sticky protocol checking is enabled by defining DATALESS_ARB_ERR_EN.
module dataless_chain_arbiter #(
    parameter int NUM_INPUTS   = 4,
    parameter int MAX_INFLIGHT = 4,
    parameter int INDEX_WIDTH  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
    parameter int CNT_WIDTH    = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    dataless_chain_arbiter_if.master bus
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                 r_state;
    logic [INDEX_WIDTH-1:0] r_ptr;
    logic [INDEX_WIDTH-1:0] r_lidx;
    logic [CNT_WIDTH-1:0]   r_cnt;

    logic                   w_credit;
    logic                   w_found;
    logic [INDEX_WIDTH-1:0] w_winner;
    logic [INDEX_WIDTH-1:0] w_candIdx;
    logic                   w_outValid;
    logic [INDEX_WIDTH-1:0] w_index;
    logic [NUM_INPUTS-1:0]  w_ready;
    logic                   w_xfer;
    logic [INDEX_WIDTH-1:0] w_nextPtr;

    assign w_credit = (r_cnt < CNT_WIDTH'(MAX_INFLIGHT));

    // First valid requester at or above ptr, wrapping modulo NUM_INPUTS.
    always_comb begin
        w_found   = 1'b0;
        w_winner  = '0;
        w_candIdx = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (int'(r_ptr) + i >= NUM_INPUTS)
                w_candIdx = r_ptr + INDEX_WIDTH'(i) - INDEX_WIDTH'(NUM_INPUTS);
            else
                w_candIdx = r_ptr + INDEX_WIDTH'(i);
            if (!w_found && bus.ins_valid[w_candIdx]) begin
                w_found  = 1'b1;
                w_winner = w_candIdx;
            end
        end
    end

    // Outputs are combinational and held at zero for as long as reset is asserted.
    always_comb begin
        w_outValid = 1'b0;
        w_index    = '0;
        w_ready    = '0;
        if (rst) begin
            if (r_state == HOLD) begin
                w_outValid = 1'b1;
                w_index    = r_lidx;
            end else if (w_credit && w_found) begin
                w_outValid = 1'b1;
                w_index    = w_winner;
            end
            if (w_outValid)
                w_ready[w_index] = bus.outs_ready;
        end
    end

    assign w_xfer    = w_outValid & bus.outs_ready;
    assign w_nextPtr = (w_index == INDEX_WIDTH'(NUM_INPUTS - 1)) ? '0 : w_index + INDEX_WIDTH'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_lidx  <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_outValid && !bus.outs_ready) begin
                        r_lidx  <= w_winner;
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.outs_ready)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase

            if (w_xfer)
                r_ptr <= w_nextPtr;

            // A return with an empty counter and no transfer is dropped.
            if (w_xfer && !bus.ret_valid)
                r_cnt <= r_cnt + CNT_WIDTH'(1);
            else if (!w_xfer && bus.ret_valid && (r_cnt != '0))
                r_cnt <= r_cnt - CNT_WIDTH'(1);
        end
    end

`ifdef DATALESS_ARB_ERR_EN
    logic r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if ((!w_xfer && bus.ret_valid && (r_cnt == '0)) ||
                     ((r_state == HOLD) && !bus.ins_valid[r_lidx])) begin
            r_err <= 1'b1;
        end
    end

    assign bus.err = r_err;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.outs_valid = w_outValid;
    assign bus.index      = w_index;
    assign bus.ins_ready  = w_ready;
    assign bus.inflight   = r_cnt;

endmodule

// File: tb/tb_dataless_chain_arbiter.sv
// Directed self-checking bench for dataless_chain_arbiter (NUM_INPUTS=4, MAX_INFLIGHT=4).
// Expected err values follow whether DATALESS_ARB_ERR_EN is defined for this build.
module tb_dataless_chain_arbiter;

    logic clk;
    logic rst;
    int   testsRun;
    int   testsFailed;
    logic expErrUnderflow;

    dataless_chain_arbiter_if #(.NUM_INPUTS(4), .MAX_INFLIGHT(4)) bus ();

    dataless_chain_arbiter #(.NUM_INPUTS(4), .MAX_INFLIGHT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [3:0] valid, input logic ready, input logic ret);
        bus.ins_valid  = valid;
        bus.outs_ready = ready;
        bus.ret_valid  = ret;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
`ifdef DATALESS_ARB_ERR_EN
        expErrUnderflow = 1'b1;
`else
        expErrUnderflow = 1'b0;
`endif
        rst = 1'b0;
        applyStimulus(4'b1111, 1'b1, 1'b0);

        // Reset holds every output low even with requesters active.
        checkOutput("rst_outs_valid", 32'(bus.outs_valid), 32'd0);
        checkOutput("rst_ins_ready",  32'(bus.ins_ready),  32'd0);
        checkOutput("rst_index",      32'(bus.index),      32'd0);
        checkOutput("rst_inflight",   32'(bus.inflight),   32'd0);
        checkOutput("rst_err",        32'(bus.err),        32'd0);
        tick();
        tick();
        rst = 1'b1;
        #1;

        // Round-robin fairness with a return every cycle after the first.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b1111, 1'b1, (i != 0));
            checkOutput($sformatf("rr_index_%0d", i),    32'(bus.index),     32'(i % 4));
            checkOutput($sformatf("rr_ready_%0d", i),    32'(bus.ins_ready), 32'(1 << (i % 4)));
            checkOutput($sformatf("rr_inflight_%0d", i), 32'(bus.inflight),  (i == 0) ? 32'd0 : 32'd1);
            tick();
        end
        applyStimulus(4'b0000, 1'b1, 1'b1);
        checkOutput("rr_idle_valid", 32'(bus.outs_valid), 32'd0);
        tick();
        checkOutput("rr_drained", 32'(bus.inflight), 32'd0);

        // Credit exhaustion: ptr=1, only requester 0 valid.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'b0001, 1'b1, 1'b0);
            checkOutput($sformatf("cr_valid_%0d", i),    32'(bus.outs_valid), 32'd1);
            checkOutput($sformatf("cr_index_%0d", i),    32'(bus.index),      32'd0);
            checkOutput($sformatf("cr_inflight_%0d", i), 32'(bus.inflight),   32'(i));
            tick();
        end
        checkOutput("cr_full_valid",    32'(bus.outs_valid), 32'd0);
        checkOutput("cr_full_ready",    32'(bus.ins_ready),  32'd0);
        checkOutput("cr_full_inflight", 32'(bus.inflight),   32'd4);
        tick();
        checkOutput("cr_still_full", 32'(bus.outs_valid), 32'd0);
        applyStimulus(4'b0001, 1'b1, 1'b1);
        checkOutput("cr_ret_same_cycle", 32'(bus.outs_valid), 32'd0);
        tick();
        applyStimulus(4'b0001, 1'b1, 1'b0);
        checkOutput("cr_reenabled_valid",    32'(bus.outs_valid), 32'd1);
        checkOutput("cr_reenabled_inflight", 32'(bus.inflight),   32'd3);
        tick();
        checkOutput("cr_one_transfer_only", 32'(bus.outs_valid), 32'd0);
        checkOutput("cr_refull_inflight",   32'(bus.inflight),   32'd4);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'b0000, 1'b1, 1'b1);
            tick();
        end
        checkOutput("cr_drained", 32'(bus.inflight), 32'd0);

        // Serve requester 3 so that ptr wraps to 0, then return its credit.
        applyStimulus(4'b1000, 1'b1, 1'b0);
        checkOutput("bp_setup_index", 32'(bus.index), 32'd3);
        tick();
        applyStimulus(4'b0000, 1'b0, 1'b1);
        tick();
        checkOutput("bp_setup_inflight", 32'(bus.inflight), 32'd0);

        // Backpressure: requester 1 wins and is held while outs_ready is low.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0110, 1'b0, 1'b0);
            checkOutput($sformatf("bp_valid_%0d", i), 32'(bus.outs_valid), 32'd1);
            checkOutput($sformatf("bp_index_%0d", i), 32'(bus.index),      32'd1);
            checkOutput($sformatf("bp_ready_%0d", i), 32'(bus.ins_ready),  32'd0);
            tick();
        end
        applyStimulus(4'b0110, 1'b1, 1'b0);
        checkOutput("bp_release_index", 32'(bus.index),     32'd1);
        checkOutput("bp_release_ready", 32'(bus.ins_ready), 32'b0010);
        tick();
        applyStimulus(4'b0100, 1'b1, 1'b0);
        checkOutput("bp_next_index",    32'(bus.index),     32'd2);
        checkOutput("bp_next_ready",    32'(bus.ins_ready), 32'b0100);
        checkOutput("bp_next_inflight", 32'(bus.inflight),  32'd1);
        tick();

        // Simultaneous transfer and return at cnt=2; ptr=3 wraps to requester 0.
        applyStimulus(4'b0001, 1'b1, 1'b1);
        checkOutput("sim_index",           32'(bus.index),    32'd0);
        checkOutput("sim_inflight_before", 32'(bus.inflight), 32'd2);
        tick();
        checkOutput("sim_inflight_after", 32'(bus.inflight), 32'd2);

        // Underflow: extra return with an empty counter.
        applyStimulus(4'b0000, 1'b1, 1'b1);
        tick();
        tick();
        checkOutput("uf_drained", 32'(bus.inflight), 32'd0);
        checkOutput("uf_err_before", 32'(bus.err), 32'd0);
        tick();
        checkOutput("uf_inflight", 32'(bus.inflight), 32'd0);
        checkOutput("uf_err",      32'(bus.err),      32'(expErrUnderflow));
        applyStimulus(4'b0000, 1'b1, 1'b0);
        tick();
        checkOutput("uf_err_sticky", 32'(bus.err), 32'(expErrUnderflow));

        // Build inflight=3 (ptr ends at 1), then hold requester 2.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0001, 1'b1, 1'b0);
            tick();
        end
        applyStimulus(4'b0100, 1'b0, 1'b0);
        tick();
        checkOutput("ar_hold_valid",    32'(bus.outs_valid), 32'd1);
        checkOutput("ar_hold_index",    32'(bus.index),      32'd2);
        checkOutput("ar_hold_inflight", 32'(bus.inflight),   32'd3);
        applyStimulus(4'b0100, 1'b1, 1'b0);
        checkOutput("ar_hold_ready", 32'(bus.ins_ready), 32'b0100);

        // Asynchronous reset between edges abandons the held token.
        #2;
        rst = 1'b0;
        #1;
        checkOutput("ar_outs_valid", 32'(bus.outs_valid), 32'd0);
        checkOutput("ar_ins_ready",  32'(bus.ins_ready),  32'd0);
        checkOutput("ar_index",      32'(bus.index),      32'd0);
        checkOutput("ar_inflight",   32'(bus.inflight),   32'd0);
        checkOutput("ar_err",        32'(bus.err),        32'd0);
        tick();
        rst = 1'b1;
        applyStimulus(4'b1111, 1'b1, 1'b0);
        checkOutput("ar_restart_index",    32'(bus.index),    32'd0);
        checkOutput("ar_restart_inflight", 32'(bus.inflight), 32'd0);
        tick();
        checkOutput("ar_restart_next_index", 32'(bus.index),    32'd1);
        checkOutput("ar_restart_count",      32'(bus.inflight), 32'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/dataless_chain_arbiter.md
# dataless_chain_arbiter

Round-robin arbiter and credit controller that shares one dataless OEHB buffer chain among NUM_INPUTS dataless elastic requesters. Each cycle it selects one valid requester, forwards its token into the chain entry, and emits the winner's index alongside it. It also bounds the number of tokens in flight to MAX_INFLIGHT using a credit counter that is replenished by a return pulse from the chain's far end. The block sits between the requester handshakes and the input side of the shared chain.

## Interface
Parameters:
- NUM_INPUTS, 4, number of requesters; legal range ≥ 2.
- MAX_INFLIGHT, 4, maximum tokens in flight; normally equal to the chain's NUM_SLOTS; legal range ≥ 1.
- INDEX_WIDTH, $clog2(NUM_INPUTS), width of the index output; always at least 1.
- CNT_WIDTH, $clog2(MAX_INFLIGHT+1), width of the credit counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- ins_valid  input  NUM_INPUTS  per-requester valid.
- ins_ready  output  NUM_INPUTS  per-requester ready.
- outs_valid  output  1  valid into the chain entry.
- outs_ready  input  1  ready from the chain entry.
- index  output  INDEX_WIDTH  winning requester; meaningful only while outs_valid=1.
- ret_valid  input  1  one-cycle pulse; one token has left the chain and its credit is returned.
- inflight  output  CNT_WIDTH  current credit-counter value.
- err  output  1  sticky protocol-error flag.

## Operation
- State is held in a two-state FSM (IDLE, HOLD), a round-robin pointer ptr (INDEX_WIDTH bits), a latched winner lidx, and a credit counter cnt.
- The credit condition is cnt < MAX_INFLIGHT.
- IDLE:
  - When the credit condition holds and any ins_valid is set, the winner is the first set bit searching upward from ptr, wrapping modulo NUM_INPUTS.
  - In that case outs_valid=1 and index=winner.
  - ins_ready[winner]=outs_ready; all other ins_ready bits are 0.
  - When outs_ready=1, the token transfers and the FSM stays in IDLE.
  - When outs_ready=0, lidx is loaded with the winner and the FSM moves to HOLD.
  - With no credit or no valid requester, outs_valid=0 and all ins_ready=0.
- HOLD:
  - outs_valid=1 and index=lidx, regardless of other requesters and of the credit condition. The credit was already reserved when arbitration occurred.
  - ins_ready[lidx]=outs_ready.
  - On outs_ready=1 the token transfers and the FSM returns to IDLE.
- On every transfer, ptr is set to (winner+1) mod NUM_INPUTS, using lidx in HOLD.
- Credit counter cnt:
  - cnt increments on transfer and decrements on ret_valid.
  - A transfer and ret_valid in the same cycle leave cnt unchanged.
  - ret_valid while cnt=0 with no simultaneous transfer is ignored and cnt stays 0.
- Whenever arbitration runs in IDLE, cnt < MAX_INFLIGHT is guaranteed, so a transfer can never overflow cnt.
- inflight = cnt.
- Requesters obey the elastic protocol: once ins_valid is asserted it stays high until ready.

## Timing
- While rst=0: FSM=IDLE, ptr=0, lidx=0, cnt=0, err=0. All outputs are forced to 0: outs_valid, ins_ready, index, inflight and err.
- Reset asserted mid-HOLD abandons the pending token with no transfer and clears all credits.
- Latency:
  - Zero cycles from ins_valid to outs_valid when in IDLE with credit available.
  - The handshake is combinational: valid to ready has no register stage.
- outs_valid and index are stable from entry into HOLD until the transfer completes.
- A credit returned in cycle N is usable for arbitration in cycle N+1.

## Configuration
- DATALESS_ARB_ERR_EN defined:
  - err is set, and stays set until reset, when ret_valid arrives while cnt=0 with no simultaneous transfer (underflow).
  - err is also set when the latched requester drops ins_valid while in HOLD (elastic-protocol violation).
- DATALESS_ARB_ERR_EN undefined: err is tied to 0 and the checking logic is absent. All other behaviour is identical in both cases.

## Test plan
- Round-robin fairness:
  - Stimulus: NUM_INPUTS=4, MAX_INFLIGHT=4, all ins_valid=1111, outs_ready=1, ret_valid pulsed every cycle.
  - Required: index sequence 0,1,2,3,0…, cnt stays at 0 or 1, one ins_ready bit high per cycle.
- Credit exhaustion:
  - Stimulus: ins_valid=0001, outs_ready=1, ret_valid=0.
  - Required: exactly 4 transfers, then outs_valid=0 and inflight=4. One ret_valid pulse re-enables exactly one transfer on the following cycle.
- Backpressure hold:
  - Stimulus: ins_valid=0110 with ptr=0, outs_ready=0 for 3 cycles, then outs_ready=1.
  - Required: index=1 held for all 4 cycles, ins_valid[2] not served during that time. After the transfer, ptr=2 and the next winner is 2.
- Simultaneous transfer and return:
  - Stimulus: cnt=2, transfer and ret_valid in the same cycle.
  - Required: inflight stays 2.
- Underflow and protocol error (DATALESS_ARB_ERR_EN defined):
  - Stimulus: ret_valid with cnt=0.
  - Required: cnt stays 0, err=1 and stays set until rst=0. With the macro undefined, err stays 0.
- Asynchronous reset:
  - Stimulus: assert rst=0 while in HOLD with inflight=3, between clock edges.
  - Required: outs_valid, ins_ready, index, inflight and err all go to 0 immediately. After release the arbiter restarts with winner search from ptr=0.
